mult8_seq: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier. It drives the existing 8-bit ripple adder `add8` with one partial-product addition per cycle and consumes its sum and carry-out. It accepts operands through a start/busy/done handshake and returns a 16-bit product after a fixed 8-cycle iteration. This is the first clocked datapath stage built on the lab adder hierarchy.

---
 rtl/mult8_seq.sv | 116 +++++++++++
 tb/tb_mult8_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult8_seq.sv
// mult8_seq: 8x8 unsigned shift-and-add multiplier.
// Adds one partial product per cycle through a ripple add8.

module add8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Ripple carry chain, one full adder per bit.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

module mult8_seq (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  m_q;
  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [2:0]  cnt_q;
  logic [15:0] prod_q;

  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [7:0]  sum;
  logic        cout;
  logic        accept;

  assign hi = acc_q[15:8];
  assign lo = acc_q[7:0];

  add8 u_add8 (
    .x    (hi),
    .y    (m_q),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  // Start is only honoured outside RUN.
  assign accept = start & (state_q != RUN);

  // Next accumulator: add M into HI when LO[0] is set, then shift right.
  always_comb begin
    if (lo[0]) begin
      acc_d = {cout, sum, lo[7:1]};
    end else begin
      acc_d = {1'b0, hi, lo[7:1]};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            m_q     <= a;
            acc_q   <= {8'h00, b};
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            prod_q  <= acc_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_mult8_seq.sv
// tb_mult8_seq: directed and random checks of mult8_seq
// against a plain a*b reference and fixed 8-edge latency.

module tb_mult8_seq;

  logic        clk;
  logic        rstb;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;

  mult8_seq dut (
    .clk     (clk),
    .rstb    (rstb),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full operation: accept edge, 7 busy edges, done at the 8th.
  task automatic run_op(input logic [7:0] x,
                        input logic [7:0] y,
                        input string tag);
    logic [15:0] exp;
    exp = 16'(x) * 16'(y);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    chk({tag, "_acc"}, {14'd0, busy, done}, 16'b10);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk({tag, "_run"}, {14'd0, busy, done}, 16'b10);
    end
    tick();
    chk({tag, "_done"}, {14'd0, busy, done}, 16'b01);
    chk({tag, "_prod"}, product, exp);
  endtask

  initial begin
    rstb  = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_bd", {14'd0, busy, done}, 16'b00);
    chk("rst_prod", product, 16'h0000);
    @(negedge clk);
    rstb = 1'b1;

    run_op(8'h0D, 8'h0B, "basic");
    tick();
    chk("hold_done", {15'd0, done}, 16'd0);
    tick();
    chk("hold_prod", product, 16'h008F);

    run_op(8'hFF, 8'hFF, "ffxff");
    tick();
    run_op(8'h00, 8'hFF, "zero");
    tick();
    run_op(8'h01, 8'hA5, "one");
    tick();
    run_op(8'h80, 8'h02, "msb");
    tick();

    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_ign", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("busy_pre", {14'd0, busy, done}, 16'b10);
    tick();
    chk("busy_done", {14'd0, busy, done}, 16'b01);
    chk("busy_prod", product, 16'h000F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_nodone", {14'd0, busy, done}, 16'b00);
    end

    run_op(8'h12, 8'h34, "b2b_1");
    run_op(8'h07, 8'h09, "b2b_2");
    tick();

    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_bd", {14'd0, busy, done}, 16'b00);
    chk("mid_rst_prod", product, 16'h0000);
    tick();
    chk("in_rst", {14'd0, busy, done}, 16'b00);
    @(negedge clk);
    rstb = 1'b1;
    tick();
    chk("post_rst", {14'd0, busy, done}, 16'b00);
    run_op(8'h02, 8'h03, "after_rst");

    for (int n = 0; n < 1000; n++) begin
      run_op(8'($urandom), 8'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
